uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//  Sits directly downstream of the UART byte receiver and consumes its Data/Rx_Done stream.
//  Extracts framed commands in the form HDR0 HDR1 ADDR LEN PAYLOAD[LEN] CHK.
//  Checks length and checksum, then holds the payload in a local buffer until firmware logic acknowledges it.
//  Reports malformed and stalled frames with an error pulse and an error code.
// PARAMETERS
//  MAX_LEN      16       max payload bytes; LEN outside 1..MAX_LEN is an error
//  TIMEOUT_CYC  50000    idle Clk cycles allowed between bytes inside a frame (1 ms @ 50 MHz)
//  HDR0         8'h55    first sync byte
//  HDR1         8'hAA    second sync byte
// PORTS
//  Clk          in   1               system clock
//  Reset_n      in   1               asynchronous, active-low reset
//  Rx_Data      in   8               received byte; valid when Rx_Done=1
//  Rx_Done      in   1               one-cycle strobe per received byte
//  Frame_Ack    in   1               consumer done with the held frame; releases the buffer
//  Rd_Addr      in   clog2(MAX_LEN)  payload read index
//  Rd_Data      out  8               payload[Rd_Addr]; registered, 1-cycle latency
//  Frame_Addr   out  8               ADDR of the held frame
//  Frame_Len    out  8               LEN of the held frame
//  Frame_Valid  out  1               one-cycle pulse when a good frame is captured
//  Frame_Busy   out  1               1 while a good frame is held (state S_HOLD)
//  Frame_Err    out  1               one-cycle pulse on any frame error
//  Err_Code     out  2               1=bad LEN, 2=checksum, 3=timeout; sticky until the next error
//  Overrun      out  1               one-cycle pulse when a byte arrives during S_HOLD (byte dropped)
// BEHAVIOUR
//  Reset: all outputs 0, state S_HDR0, checksum/timeout counters 0, buffer contents don't-care.
//  FSM advances only on Rx_Done. States and transitions:
//   S_HDR0: byte==HDR0 -> S_HDR1; otherwise stay.
//   S_HDR1: byte==HDR1 -> S_ADDR; byte==HDR0 -> stay (resync); otherwise -> S_HDR0.
//   S_ADDR: latch Frame_Addr; sum<=byte -> S_LEN.
//   S_LEN: 0 or >MAX_LEN -> Frame_Err, Err_Code=1, S_HDR0.
//          Otherwise latch Frame_Len, sum+=byte, idx<=0 -> S_DATA.
//   S_DATA: buf[idx]<=byte; sum+=byte; idx+=1. Go to S_CHK after the LEN-th byte.
//   S_CHK: byte==sum[7:0] -> Frame_Valid pulse (cycle after Rx_Done), S_HOLD.
//          Otherwise -> Frame_Err, Err_Code=2, S_HDR0.
//   S_HOLD: Frame_Ack -> S_HDR0 next cycle. Rx_Done -> Overrun pulse, byte discarded.
//  Checksum: 8-bit sum modulo 256 over ADDR, LEN and payload; headers excluded.
//  Timeout counter:
//   - Cleared on every Rx_Done; counts in S_HDR1..S_CHK; held at 0 in S_HDR0/S_HOLD.
//   - Reaching TIMEOUT_CYC-1 in S_HDR1 -> silent return to S_HDR0.
//   - Reaching it in S_ADDR..S_CHK -> Frame_Err, Err_Code=3, S_HDR0.
//  Simultaneous events:
//   - Frame_Ack and Rx_Done in S_HOLD: byte dropped with Overrun; S_HDR0 next cycle.
//   - Rx_Done and timeout expiry on the same cycle: the byte wins and the counter clears.
//  Frame_Addr/Frame_Len/buffer stay stable through S_HOLD; they are overwritten only by the next frame.
//  Reset mid-frame: immediate return to S_HDR0; no Frame_Err or Frame_Valid generated.
//  Rd_Data is defined only while Frame_Busy=1; Rd_Addr>=Frame_Len returns stale data.
// STRUCTURE
//  Package uart_pkg holds:
//   - the FSM state encoding (7 states, 3 bits);
//   - ERR_NONE/ERR_LEN/ERR_CHK/ERR_TMO codes;
//   - default header bytes shared with the future transmit framer.
//  Sub-module uart_frame_buf: MAX_LEN x 8 single-write, single-read register file.
//   - Write port driven from S_DATA; read port registered.
//  FSM, checksum adder and timeout counter stay in the top module.
// TESTING
//  1 good frame 55 AA 03 02 11 22 38 -> Frame_Valid=1 for 1 cycle, Frame_Busy=1, Addr=03, Len=02;
//    Rd_Addr=0/1 -> Rd_Data=11/22.
//  2 same frame with CHK=39 -> Frame_Err pulse, Err_Code=2, no Frame_Valid, Frame_Busy=0.
//  3 55 AA 07 00 -> Frame_Err, Err_Code=1. Then 55 AA 07 11 (len 17 > 16) -> Err_Code=1 again.
//  4 55 AA 03, then no byte for TIMEOUT_CYC cycles -> Frame_Err, Err_Code=3; a following good frame is accepted.
//  5 noise 12 55 55 AA 01 01 5A 5C -> resync accepted, Frame_Valid, Rd_Data[0]=5A.
//  6 frame held, extra byte 77 -> Overrun pulse, buffer unchanged.
//    Frame_Ack -> Busy drops; Reset_n low mid-payload -> all outputs 0, next frame parses cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command framing path: parser FSM states,
// error codes and the default sync bytes, also used by the future transmit framer.
package uart_pkg;

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_ADDR = 3'd2,
        S_LEN  = 3'd3,
        S_DATA = 3'd4,
        S_CHK  = 3'd5,
        S_HOLD = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CHK  = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_t;

    localparam logic [7:0] HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

    // States in which the inter-byte timeout counter runs.
    function automatic logic in_frame(state_t s);
        return (s inside {S_HDR1, S_ADDR, S_LEN, S_DATA, S_CHK});
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte stream in, held-frame readout out. The parser takes the slave side;
// the byte source and the consuming firmware logic take the master side.
interface uart_frame_parser_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int AW = $clog2(MAX_LEN);

    logic [7:0]    Rx_Data;
    logic          Rx_Done;
    logic          Frame_Ack;
    logic [AW-1:0] Rd_Addr;
    logic [7:0]    Rd_Data;
    logic [7:0]    Frame_Addr;
    logic [7:0]    Frame_Len;
    logic          Frame_Valid;
    logic          Frame_Busy;
    logic          Frame_Err;
    logic [1:0]    Err_Code;
    logic          Overrun;

    modport slave (
        input  Rx_Data, Rx_Done, Frame_Ack, Rd_Addr,
        output Rd_Data, Frame_Addr, Frame_Len, Frame_Valid, Frame_Busy,
               Frame_Err, Err_Code, Overrun
    );

    modport master (
        output Rx_Data, Rx_Done, Frame_Ack, Rd_Addr,
        input  Rd_Data, Frame_Addr, Frame_Len, Frame_Valid, Frame_Busy,
               Frame_Err, Err_Code, Overrun
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: single write port, registered single read port.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto plain flops/LUTRAM; only the read register is reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts HDR0 HDR1 ADDR LEN PAYLOAD CHK frames from a UART byte stream,
// validates them and holds the payload until the consumer acknowledges.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] HDR0        = HDR0_DEFAULT,
    parameter logic [7:0] HDR1        = HDR1_DEFAULT
) (
    input logic                Clk,
    input logic                Reset_n,
    uart_frame_parser_if.slave frame_bus
);

    localparam int            AW        = $clog2(MAX_LEN);
    localparam int            TW        = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    logic       rx_done;
    logic [7:0] rx_data;
    assign rx_done = frame_bus.Rx_Done;
    assign rx_data = frame_bus.Rx_Data;

    state_t        state_q, state_d;
    logic [7:0]    sum_q;
    logic [AW-1:0] idx_q;
    logic [7:0]    addr_q, len_q;
    logic [TW-1:0] tmo_q;

    logic      len_bad, last_byte, chk_ok, tmo_hit;
    logic      valid_d, err_d, overrun_d;
    err_code_t err_code_d;
    logic      valid_q, err_q, overrun_q;
    err_code_t err_code_q;

    assign len_bad   = (rx_data == 8'h00) || (rx_data > MAX_LEN_B);
    assign last_byte = ((8'(idx_q) + 8'd1) == len_q);
    assign chk_ok    = (rx_data == sum_q);
    // A byte arriving on the expiry cycle wins, so expiry is qualified by !rx_done.
    assign tmo_hit   = in_frame(state_q) && !rx_done && (tmo_q == TMO_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HDR0: if (rx_done && rx_data == HDR0) state_d = S_HDR1;
            S_HDR1: if (rx_done) begin
                        if (rx_data == HDR1)      state_d = S_ADDR;
                        else if (rx_data != HDR0) state_d = S_HDR0;
                    end
            S_ADDR: if (rx_done) state_d = S_LEN;
            S_LEN:  if (rx_done) state_d = len_bad ? S_HDR0 : S_DATA;
            S_DATA: if (rx_done && last_byte) state_d = S_CHK;
            S_CHK:  if (rx_done) state_d = chk_ok ? S_HOLD : S_HDR0;
            S_HOLD: if (frame_bus.Frame_Ack) state_d = S_HDR0;
            default: state_d = S_HDR0;
        endcase
        if (tmo_hit) state_d = S_HDR0;
    end

    always_comb begin
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
        overrun_d  = 1'b0;
        if (rx_done) begin
            unique case (state_q)
                S_LEN:  if (len_bad) begin err_d = 1'b1; err_code_d = ERR_LEN; end
                S_CHK:  if (chk_ok) valid_d = 1'b1;
                        else begin err_d = 1'b1; err_code_d = ERR_CHK; end
                S_HOLD: overrun_d = 1'b1;
                default: ;
            endcase
        end else if (tmo_hit && state_q != S_HDR1) begin
            err_d      = 1'b1;
            err_code_d = ERR_TMO;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            valid_q   <= valid_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            if (err_d) err_code_q <= err_code_d;
        end
    end

    // Header fields and running checksum; untouched in S_HOLD so the held frame stays stable.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sum_q  <= 8'h00;
            idx_q  <= '0;
            addr_q <= 8'h00;
            len_q  <= 8'h00;
        end else if (rx_done) begin
            unique case (state_q)
                S_ADDR: begin
                    addr_q <= rx_data;
                    sum_q  <= rx_data;
                end
                S_LEN: if (!len_bad) begin
                    len_q <= rx_data;
                    sum_q <= sum_q + rx_data;
                    idx_q <= '0;
                end
                S_DATA: begin
                    sum_q <= sum_q + rx_data;
                    idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_q <= '0;
        end else if (rx_done || tmo_hit || !in_frame(state_q)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wr_en   (rx_done && state_q == S_DATA),
        .wr_addr (idx_q),
        .wr_data (rx_data),
        .rd_addr (frame_bus.Rd_Addr),
        .rd_data (frame_bus.Rd_Data)
    );

    assign frame_bus.Frame_Addr  = addr_q;
    assign frame_bus.Frame_Len   = len_q;
    assign frame_bus.Frame_Valid = valid_q;
    assign frame_bus.Frame_Busy  = (state_q == S_HOLD);
    assign frame_bus.Frame_Err   = err_q;
    assign frame_bus.Err_Code    = err_code_q;
    assign frame_bus.Overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: each scenario queues the pulses it expects
// and a negedge monitor pops and compares them as the parser emits them.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 100;

    typedef enum logic [1:0] {EV_VALID, EV_ERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [1:0] code;
        logic [7:0] addr;
        logic [7:0] len;
    } ev_t;

    logic Clk;
    logic Reset_n;
    int   checks   = 0;
    int   failures = 0;

    ev_t        exp_q[$];
    logic [7:0] tx_q[$];

    uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_frame_parser #(
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every pulse cycle must match the head of the expected queue.
    always @(negedge Clk) begin
        if (bus.Frame_Valid || bus.Frame_Err || bus.Overrun) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event got valid=%0b err=%0b ovr=%0b code=%0d, required none",
                         bus.Frame_Valid, bus.Frame_Err, bus.Overrun, bus.Err_Code);
            end else begin
                ev_t e;
                ev_kind_t k;
                e = exp_q.pop_front();
                k = bus.Frame_Valid ? EV_VALID : (bus.Frame_Err ? EV_ERR : EV_OVR);
                if (k != e.kind || $countones({bus.Frame_Valid, bus.Frame_Err, bus.Overrun}) != 1 ||
                    (k == EV_ERR && bus.Err_Code !== e.code) ||
                    (k == EV_VALID && {bus.Frame_Addr, bus.Frame_Len} !== {e.addr, e.len})) begin
                    failures++;
                    $display("FAIL event got valid=%0b err=%0b ovr=%0b code=%0d addr=%02h len=%02h required %s code=%0d addr=%02h len=%02h",
                             bus.Frame_Valid, bus.Frame_Err, bus.Overrun, bus.Err_Code,
                             bus.Frame_Addr, bus.Frame_Len, e.kind.name(), e.code, e.addr, e.len);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        bus.Rx_Data = b;
        bus.Rx_Done = 1'b1;
        @(negedge Clk);
        bus.Rx_Done = 1'b0;
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [1:0] c,
                             input logic [7:0] a, input logic [7:0] l);
        ev_t e;
        e.kind = k; e.code = c; e.addr = a; e.len = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge Clk); #1;
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic pulse_ack();
        @(negedge Clk);
        bus.Frame_Ack = 1'b1;
        @(negedge Clk);
        bus.Frame_Ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        bus.Rx_Data = 8'h00;
        bus.Rx_Done = 1'b0;
        bus.Frame_Ack = 1'b0;
        bus.Rd_Addr = '0;
        repeat (3) @(negedge Clk);
        #1;
        checks++;
        if ({bus.Frame_Valid, bus.Frame_Busy, bus.Frame_Err, bus.Overrun, bus.Err_Code} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got %b required 000000",
                     {bus.Frame_Valid, bus.Frame_Busy, bus.Frame_Err, bus.Overrun, bus.Err_Code});
        end
        checks++;
        if ({bus.Frame_Addr, bus.Frame_Len, bus.Rd_Data} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got %06h required 000000",
                     {bus.Frame_Addr, bus.Frame_Len, bus.Rd_Data});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic test_good_frame();
        bit ok;
        logic [7:0] exp_pl[2];
        exp_pl[0] = 8'h11; exp_pl[1] = 8'h22;
        expect_ev(EV_VALID, 2'd0, 8'h03, 8'h02);
        tx_q = '{8'h55, 8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h38};
        send_q();
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL good_frame_valid got missing required pulse"); end
        checks++;
        if (bus.Frame_Busy !== 1'b1) begin
            failures++; $display("FAIL good_frame_busy got %b required 1", bus.Frame_Busy);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            bus.Rd_Addr = 4'(i);
            @(negedge Clk); #1;
            checks++;
            if (bus.Rd_Data !== exp_pl[i]) begin
                failures++; $display("FAIL good_frame_rd%0d got %02h required %02h", i, bus.Rd_Data, exp_pl[i]);
            end
        end
        pulse_ack();
        checks++;
        if (bus.Frame_Busy !== 1'b0) begin
            failures++; $display("FAIL ack_busy got %b required 0", bus.Frame_Busy);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] exp_pl[2];
        exp_pl[0] = 8'h11; exp_pl[1] = 8'h22;
        expect_ev(EV_VALID, 2'd0, 8'h03, 8'h02);
        expect_ev(EV_OVR, 2'd0, 8'h00, 8'h00);
        tx_q = '{8'h55, 8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h38, 8'h77};
        send_q();
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL overrun_pulse got missing required pulse"); end
        checks++;
        if ({bus.Frame_Busy, bus.Frame_Addr, bus.Frame_Len} !== {1'b1, 8'h03, 8'h02}) begin
            failures++;
            $display("FAIL overrun_hold got busy=%b addr=%02h len=%02h required busy=1 addr=03 len=02",
                     bus.Frame_Busy, bus.Frame_Addr, bus.Frame_Len);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            bus.Rd_Addr = 4'(i);
            @(negedge Clk); #1;
            checks++;
            if (bus.Rd_Data !== exp_pl[i]) begin
                failures++; $display("FAIL overrun_rd%0d got %02h required %02h", i, bus.Rd_Data, exp_pl[i]);
            end
        end
        // Ack and a byte on the same cycle: byte dropped with Overrun, buffer released.
        expect_ev(EV_OVR, 2'd0, 8'h00, 8'h00);
        @(negedge Clk);
        bus.Rx_Data = 8'h55;
        bus.Rx_Done = 1'b1;
        bus.Frame_Ack = 1'b1;
        @(negedge Clk);
        bus.Rx_Done = 1'b0;
        bus.Frame_Ack = 1'b0;
        #1;
        wait_drain(ok);
        checks++;
        if (!ok || bus.Frame_Busy !== 1'b0) begin
            failures++; $display("FAIL ack_and_byte got busy=%b drained=%b required busy=0 drained=1", bus.Frame_Busy, ok);
        end
    endtask

    task automatic test_bad_chk();
        bit ok;
        expect_ev(EV_ERR, 2'd2, 8'h00, 8'h00);
        tx_q = '{8'h55, 8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h39};
        send_q();
        wait_drain(ok);
        checks++;
        if (!ok || bus.Frame_Busy !== 1'b0 || bus.Err_Code !== 2'd2) begin
            failures++;
            $display("FAIL bad_chk got drained=%b busy=%b code=%0d required drained=1 busy=0 code=2",
                     ok, bus.Frame_Busy, bus.Err_Code);
        end
    endtask

    task automatic test_bad_len();
        bit ok;
        expect_ev(EV_ERR, 2'd1, 8'h00, 8'h00);
        tx_q = '{8'h55, 8'hAA, 8'h07, 8'h00};
        send_q();
        wait_drain(ok);
        checks++;
        if (!ok || bus.Err_Code !== 2'd1) begin
            failures++; $display("FAIL bad_len_zero got drained=%b code=%0d required drained=1 code=1", ok, bus.Err_Code);
        end
        expect_ev(EV_ERR, 2'd1, 8'h00, 8'h00);
        tx_q = '{8'h55, 8'hAA, 8'h07, 8'h11};
        send_q();
        wait_drain(ok);
        checks++;
        if (!ok || bus.Err_Code !== 2'd1 || bus.Frame_Busy !== 1'b0) begin
            failures++; $display("FAIL bad_len_17 got drained=%b code=%0d busy=%b required drained=1 code=1 busy=0",
                                 ok, bus.Err_Code, bus.Frame_Busy);
        end
    endtask

    task automatic test_max_len();
        bit ok;
        logic [7:0] pl[MAX_LEN];
        logic [7:0] sum;
        sum = 8'h42 + 8'(MAX_LEN);
        tx_q = '{8'h55, 8'hAA, 8'h42, 8'(MAX_LEN)};
        for (int i = 0; i < MAX_LEN; i++) begin
            pl[i] = 8'($urandom_range(0, 255));
            sum   = sum + pl[i];
            tx_q.push_back(pl[i]);
        end
        tx_q.push_back(sum);
        expect_ev(EV_VALID, 2'd0, 8'h42, 8'(MAX_LEN));
        send_q();
        wait_drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL max_len_valid got missing required pulse"); end
        for (int i = 0; i < MAX_LEN; i++) begin
            @(negedge Clk);
            bus.Rd_Addr = 4'(i);
            @(negedge Clk); #1;
            checks++;
            if (bus.Rd_Data !== pl[i]) begin
                failures++; $display("FAIL max_len_rd%0d got %02h required %02h", i, bus.Rd_Data, pl[i]);
            end
        end
        pulse_ack();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        expect_ev(EV_ERR, 2'd3, 8'h00, 8'h00);
        tx_q = '{8'h55, 8'hAA, 8'h03};
        send_q();
        n = 0;
        while (!bus.Frame_Err && n < TMO + 20) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n != TMO || bus.Err_Code !== 2'd3) begin
            failures++; $display("FAIL timeout_latency got %0d cycles code=%0d required %0d cycles code=3", n, bus.Err_Code, TMO);
        end
        wait_drain(ok);
        // Recovery, with the next byte landing exactly on the expiry cycle.
        expect_ev(EV_VALID, 2'd0, 8'h03, 8'h02);
        tx_q = '{8'h55, 8'hAA, 8'h03};
        send_q();
        repeat (TMO - 2) @(negedge Clk);
        tx_q = '{8'h02, 8'h11, 8'h22, 8'h38};
        send_q();
        wait_drain(ok);
        checks++;
        if (!ok || bus.Frame_Busy !== 1'b1) begin
            failures++; $display("FAIL timeout_byte_wins got drained=%b busy=%b required drained=1 busy=1", ok, bus.Frame_Busy);
        end
        pulse_ack();
        // Expiry in S_HDR1 is silent; the rest of that frame is then ignored.
        send_byte(8'h55);
        repeat (TMO + 5) @(negedge Clk);
        tx_q = '{8'hAA, 8'h03, 8'h02, 8'h11, 8'h22, 8'h38};
        send_q();
        repeat (5) @(negedge Clk);
        #1;
        checks++;
        if (bus.Frame_Busy !== 1'b0 || bus.Err_Code !== 2'd3) begin
            failures++; $display("FAIL hdr1_timeout got busy=%b code=%0d required busy=0 code=3", bus.Frame_Busy, bus.Err_Code);
        end
    endtask

    task automatic test_resync();
        bit ok;
        expect_ev(EV_VALID, 2'd0, 8'h01, 8'h01);
        tx_q = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h01, 8'h5A, 8'h5C};
        send_q();
        wait_drain(ok);
        @(negedge Clk);
        bus.Rd_Addr = 4'd0;
        @(negedge Clk); #1;
        checks++;
        if (!ok || bus.Rd_Data !== 8'h5A) begin
            failures++; $display("FAIL resync got drained=%b rd0=%02h required drained=1 rd0=5A", ok, bus.Rd_Data);
        end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        bit ok;
        tx_q = '{8'h55, 8'hAA, 8'h03, 8'h04, 8'h11};
        send_q();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.Frame_Valid, bus.Frame_Busy, bus.Frame_Err, bus.Overrun, bus.Err_Code,
             bus.Frame_Addr, bus.Frame_Len, bus.Rd_Data} !== 30'h0) begin
            failures++;
            $display("FAIL reset_mid got code=%0d addr=%02h len=%02h rd=%02h busy=%b required all zero",
                     bus.Err_Code, bus.Frame_Addr, bus.Frame_Len, bus.Rd_Data, bus.Frame_Busy);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        expect_ev(EV_VALID, 2'd0, 8'h05, 8'h01);
        tx_q = '{8'h55, 8'hAA, 8'h05, 8'h01, 8'h99, 8'h9F};
        send_q();
        wait_drain(ok);
        @(negedge Clk);
        bus.Rd_Addr = 4'd0;
        @(negedge Clk); #1;
        checks++;
        if (!ok || bus.Rd_Data !== 8'h99) begin
            failures++; $display("FAIL after_reset got drained=%b rd0=%02h required drained=1 rd0=99", ok, bus.Rd_Data);
        end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_overrun();
        test_bad_chk();
        test_bad_len();
        test_max_len();
        test_timeout();
        test_resync();
        test_reset_mid();
        repeat (5) @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL leftover_events got %0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
